// File: rtl/upsampler_if.sv
// Symbol handshake and oversampled-output bundle of the upsampler.
// The master side is the symbol source / sample sink; the slave side is the upsampler.
interface upsampler_if #(
  parameter int WL = 2
);
  logic                 i_valid;
  logic signed [WL-1:0] i_ak;
  logic                 o_ready;
  logic signed [WL-1:0] o_ak;
  logic                 o_valid;
  logic                 o_strobe;
  logic                 o_underflow;

  modport master (
    output i_valid, i_ak,
    input  o_ready, o_ak, o_valid, o_strobe, o_underflow
  );

  modport slave (
    input  i_valid, i_ak,
    output o_ready, o_ak, o_valid, o_strobe, o_underflow
  );
endinterface

// File: rtl/upsampler.sv
// Symbol-rate to sample-rate upsampler: one buffered symbol is placed on the PHASE
// slot of every N_OS enabled cycles; other slots are zero-stuffed or hold the last symbol.
module upsampler #(
  parameter int WL    = 2,
  parameter int N_OS  = 4,
  parameter int PHASE = 0,
  parameter int HOLD  = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  upsampler_if.slave  bus
);

  localparam int CL = (N_OS > 2) ? $clog2(N_OS) : 1;
  localparam logic [CL-1:0] LAST_SLOT  = CL'(N_OS - 1);
  localparam logic [CL-1:0] PHASE_SLOT = CL'(PHASE);

  typedef logic signed [WL-1:0] sample_t;

  logic [CL-1:0] slot_q;
  logic          full_q;
  sample_t       buf_q;
  sample_t       last_q;
  sample_t       ak_q;
  logic          valid_q;
  logic          strobe_q;
  logic          underflow_q;

  logic          accept;
  logic          consume;
  sample_t       ak_d;
  sample_t       last_d;

  // Ready falls with reset as well, so a source never sees a transfer that reset discards.
  assign bus.o_ready = !full_q && !i_reset;
  assign accept      = bus.i_valid && bus.o_ready;
  assign consume     = i_enable && (slot_q == PHASE_SLOT);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    ak_d   = ak_q;
    last_d = last_q;
    if (consume) begin
      ak_d   = full_q ? buf_q : '0;
      last_d = ak_d;
    end else if (i_enable) begin
      ak_d   = (HOLD != 0) ? last_q : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slot_q <= '0;
    end else if (i_enable) begin
      slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    end
  end

  // A symbol accepted in a consume cycle is not bypassed; it waits for the next PHASE slot.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q <= 1'b1;
    end else if (consume) begin
      full_q <= 1'b0;
    end
  end

  // NOTE: the buffer data register has no reset; full_q alone decides whether it is meaningful.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      buf_q <= bus.i_ak;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ak_q        <= '0;
      last_q      <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ak_q        <= ak_d;
      last_q      <= last_d;
      valid_q     <= i_enable;
      strobe_q    <= consume;
      underflow_q <= consume && !full_q;
    end
  end

  assign bus.o_ak        = ak_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_strobe    = strobe_q;
  assign bus.o_underflow = underflow_q;

  a_nos_legal: assert property (@(posedge i_clk) (N_OS >= 2) && (N_OS <= 16))
    else $error("upsampler: N_OS=%0d outside 2..16", N_OS);

  a_phase_legal: assert property (@(posedge i_clk) (PHASE >= 0) && (PHASE < N_OS))
    else $error("upsampler: PHASE=%0d must be below N_OS=%0d", PHASE, N_OS);

  a_no_overwrite: assert property (@(posedge i_clk) disable iff (i_reset) full_q |-> !accept)
    else $error("upsampler: symbol accepted while buffer full");

  a_underflow_on_slot: assert property (@(posedge i_clk) disable iff (i_reset) underflow_q |-> strobe_q)
    else $error("upsampler: underflow outside the PHASE slot");

endmodule

// File: tb/tb_upsampler.sv
// Self-checking bench for upsampler: two instances (PHASE=0/HOLD=0 and PHASE=2/HOLD=1)
// against a queue-based reference model, a vector table and hand-written corner sequences.
module tb_upsampler;

  localparam int WL   = 2;
  localparam int N_OS = 4;
  localparam int PH [2] = '{0, 2};
  localparam int HD [2] = '{0, 1};

  typedef logic signed [WL-1:0] sample_t;

  typedef struct {
    logic    en;
    logic    valid;
    sample_t ak;
    logic    rdy;
    sample_t o_ak;
    logic    strobe;
    logic    uf;
  } vec_t;

  logic i_clk    = 1'b0;
  logic i_reset  = 1'b1;
  logic i_enable = 1'b0;

  always #5 i_clk = ~i_clk;

  upsampler_if #(.WL(WL)) bus0 ();
  upsampler_if #(.WL(WL)) bus1 ();

  upsampler #(.WL(WL), .N_OS(N_OS), .PHASE(0), .HOLD(0)) dut0 (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .bus      (bus0.slave)
  );

  upsampler #(.WL(WL), .N_OS(N_OS), .PHASE(2), .HOLD(1)) dut1 (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .bus      (bus1.slave)
  );

  logic    drv_valid [2];
  sample_t drv_ak    [2];
  logic    mon_ready [2];
  logic    mon_valid [2];
  logic    mon_strobe[2];
  logic    mon_uf    [2];
  sample_t mon_ak    [2];

  assign bus0.i_valid  = drv_valid[0];
  assign bus0.i_ak     = drv_ak[0];
  assign bus1.i_valid  = drv_valid[1];
  assign bus1.i_ak     = drv_ak[1];
  assign mon_ready[0]  = bus0.o_ready;
  assign mon_valid[0]  = bus0.o_valid;
  assign mon_strobe[0] = bus0.o_strobe;
  assign mon_uf[0]     = bus0.o_underflow;
  assign mon_ak[0]     = bus0.o_ak;
  assign mon_ready[1]  = bus1.o_ready;
  assign mon_valid[1]  = bus1.o_valid;
  assign mon_strobe[1] = bus1.o_strobe;
  assign mon_uf[1]     = bus1.o_underflow;
  assign mon_ak[1]     = bus1.o_ak;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: enabled-cycle count gives the slot, a queue holds the pending symbol.
  int      m_ecnt;
  sample_t m_ak    [2];
  sample_t m_last  [2];
  logic    m_valid [2];
  logic    m_strobe[2];
  logic    m_uf    [2];
  sample_t m_pend  [2][$];

  bit      use_src [2];
  sample_t src_q   [2][$];
  sample_t sb_acc  [2][$];
  sample_t sb_emit [2][$];
  int      uf_count[2];
  logic    pre_ready[2];

  task automatic check(input string name, input int lane,
                       input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s lane%0d: got %0d, expected %0d at %0t", name, lane, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ecnt = 0;
    for (int l = 0; l < 2; l++) begin
      m_ak[l]     = '0;
      m_last[l]   = '0;
      m_valid[l]  = 1'b0;
      m_strobe[l] = 1'b0;
      m_uf[l]     = 1'b0;
      m_pend[l].delete();
      src_q[l].delete();
      sb_acc[l].delete();
      sb_emit[l].delete();
      uf_count[l] = 0;
      drv_valid[l] = 1'b0;
      drv_ak[l]    = '0;
    end
  endtask

  task automatic apply_reset();
    i_reset  = 1'b1;
    i_enable = 1'b0;
    for (int l = 0; l < 2; l++) drv_valid[l] = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    model_clear();
    #1;
    for (int l = 0; l < 2; l++) begin
      check("rst_o_ak",        l, mon_ak[l],     0);
      check("rst_o_valid",     l, mon_valid[l],  0);
      check("rst_o_strobe",    l, mon_strobe[l], 0);
      check("rst_o_underflow", l, mon_uf[l],     0);
      check("rst_o_ready",     l, mon_ready[l],  1);
    end
  endtask

  // One clock: drive, check ready before the edge, advance the model, compare after the edge.
  task automatic cycle(input logic en);
    logic acc [2];
    int   slot;
    for (int l = 0; l < 2; l++) begin
      if (use_src[l]) begin
        drv_valid[l] = (src_q[l].size() > 0);
        drv_ak[l]    = (src_q[l].size() > 0) ? src_q[l][0] : sample_t'($urandom);
      end
    end
    i_enable = en;
    #1;
    for (int l = 0; l < 2; l++) begin
      pre_ready[l] = mon_ready[l];
      check("o_ready", l, mon_ready[l], (m_pend[l].size() == 0));
      acc[l] = drv_valid[l] && (m_pend[l].size() == 0);
    end
    @(posedge i_clk);
    #1;
    slot = m_ecnt % N_OS;
    for (int l = 0; l < 2; l++) begin
      if (en) begin
        m_valid[l] = 1'b1;
        if (slot == PH[l]) begin
          m_strobe[l] = 1'b1;
          if (m_pend[l].size() > 0) begin
            m_ak[l] = m_pend[l].pop_front();
            m_uf[l] = 1'b0;
          end else begin
            m_ak[l] = '0;
            m_uf[l] = 1'b1;
          end
          m_last[l] = m_ak[l];
        end else begin
          m_strobe[l] = 1'b0;
          m_uf[l]     = 1'b0;
          m_ak[l]     = (HD[l] != 0) ? m_last[l] : '0;
        end
      end else begin
        m_valid[l]  = 1'b0;
        m_strobe[l] = 1'b0;
        m_uf[l]     = 1'b0;
      end
      if (acc[l]) begin
        m_pend[l].push_back(drv_ak[l]);
        sb_acc[l].push_back(drv_ak[l]);
        if (use_src[l] && src_q[l].size() > 0) void'(src_q[l].pop_front());
      end
      check("o_ak",        l, mon_ak[l],     m_ak[l]);
      check("o_valid",     l, mon_valid[l],  m_valid[l]);
      check("o_strobe",    l, mon_strobe[l], m_strobe[l]);
      check("o_underflow", l, mon_uf[l],     m_uf[l]);
      if (mon_valid[l] && mon_strobe[l] && !mon_uf[l]) sb_emit[l].push_back(mon_ak[l]);
      if (mon_uf[l]) uf_count[l]++;
    end
    if (en) m_ecnt++;
  endtask

  // Everything accepted and already due must have come out once, in order.
  task automatic check_sb();
    for (int l = 0; l < 2; l++) begin
      int n;
      n = sb_acc[l].size() - m_pend[l].size();
      check("sb_count", l, sb_emit[l].size(), n);
      for (int i = 0; i < n && i < sb_emit[l].size(); i++)
        check("sb_data", l, sb_emit[l][i], sb_acc[l][i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [17];
    int   ak_in [17]  = '{1, -1, -1, -1, -1, -1, -2, -2, -2, -2, 0, 0, 0, 0, 0, 0, 0};
    int   rdy_ex [17] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    int   oak_ex [17] = '{0, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0, 0, -2, 0, 0, 0, 0};
    int   l1_ak [16]  = '{0, 0, 1, 1, 1, 1, -1, -1, -1, -1, -2, -2, -2, -2, 0, 0};

    for (int i = 0; i < 17; i++) begin
      tbl[i].en     = 1'b1;
      tbl[i].valid  = (i < 14);
      tbl[i].ak     = sample_t'(ak_in[i]);
      tbl[i].rdy    = rdy_ex[i][0];
      tbl[i].o_ak   = sample_t'(oak_ex[i]);
      tbl[i].strobe = (i % 4 == 0);
      tbl[i].uf     = (i == 0);
    end

    model_clear();

    // Continuous enable, symbols 1,-1,-2,0: lane 0 from the table, lane 1 from its source queue.
    apply_reset();
    use_src[0] = 1'b0;
    use_src[1] = 1'b1;
    src_q[1] = '{1, -1, -2, 0};
    for (int i = 0; i < 17; i++) begin
      drv_valid[0] = tbl[i].valid;
      drv_ak[0]    = tbl[i].ak;
      cycle(tbl[i].en);
      check("tbl_ready",     0, pre_ready[0],  tbl[i].rdy);
      check("tbl_o_ak",      0, mon_ak[0],     tbl[i].o_ak);
      check("tbl_strobe",    0, mon_strobe[0], tbl[i].strobe);
      check("tbl_underflow", 0, mon_uf[0],     tbl[i].uf);
      if (i < 16) begin
        check("hold_o_ak",   1, mon_ak[1],     l1_ak[i]);
        check("hold_strobe", 1, mon_strobe[1], (i % 4 == 2));
      end
    end
    check_sb();

    // Enable toggling with one symbol preloaded: emitted once, next slot underflows.
    apply_reset();
    use_src[0] = 1'b1;
    use_src[1] = 1'b1;
    src_q[0] = '{1};
    src_q[1] = '{1};
    cycle(1'b0);
    for (int i = 0; i < 16; i++) cycle((i % 2) == 0);
    for (int l = 0; l < 2; l++) begin
      check("gap_emits",     l, sb_emit[l].size(), 1);
      check("gap_underflow", l, uf_count[l],       1);
    end
    check_sb();

    // Source stalls for two baud periods after one symbol, then resumes.
    apply_reset();
    src_q[0] = '{1};
    src_q[1] = '{1};
    cycle(1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1);
    for (int l = 0; l < 2; l++) check("stall_underflow", l, uf_count[l], 2);
    src_q[0].push_back(-2);
    src_q[1].push_back(-2);
    for (int i = 0; i < 8; i++) cycle(1'b1);
    for (int l = 0; l < 2; l++) check("resume_emits", l, sb_emit[l].size(), 2);
    check_sb();

    // Random enable gaps, valid and data: data changes while full must be ignored.
    apply_reset();
    use_src[0] = 1'b0;
    use_src[1] = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      for (int l = 0; l < 2; l++) begin
        drv_valid[l] = ($urandom_range(0, 3) != 0);
        drv_ak[l]    = sample_t'($urandom);
      end
      cycle($urandom_range(0, 3) != 0);
    end
    check_sb();

    // Reset mid-period with both buffers full: pending symbol -2 is discarded.
    apply_reset();
    use_src[0] = 1'b1;
    use_src[1] = 1'b1;
    src_q[0] = '{1, -2};
    src_q[1] = '{1, -2};
    cycle(1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1);
    for (int l = 0; l < 2; l++) check("pre_rst_full", l, m_pend[l].size(), 1);
    check_sb();
    #2;
    i_reset = 1'b1;
    #1;
    for (int l = 0; l < 2; l++) begin
      check("async_o_ak",   l, mon_ak[l],    0);
      check("async_ready",  l, mon_ready[l], 0);
      check("async_valid",  l, mon_valid[l], 0);
    end
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1);
      if (i == 0) check("realign_slot0", 0, mon_uf[0], 1);
    end
    for (int l = 0; l < 2; l++) check("discarded_absent", l, sb_emit[l].size(), 0);
    check_sb();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/upsampler.md
Name: upsampler

Overview:
- Transmit-side counterpart of the symbol downsampler.
- Accepts one WL-bit signed symbol per baud period through a valid/ready handshake and emits an N_OS-times oversampled stream at the clock rate.
- The symbol is placed on a programmable phase slot; the remaining slots are zero-stuffed or held.
- Sits between the symbol source (PRBS/mapper) and the pulse-shaping filter, clocked by the sample-rate i_enable tick.

Parameters:
- WL, 2, symbol width in bits, signed two's complement.
- N_OS, 4, oversampling factor; legal range 2..16.
- PHASE, 0, output slot (0..N_OS-1) that carries the symbol.
- HOLD, 0, 0 = zero-stuff non-symbol slots; 1 = repeat the last emitted symbol.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  sample-rate tick; one output sample per cycle with i_enable=1.
- i_valid  in  1  upstream symbol valid.
- i_ak  in  WL  upstream symbol, signed.
- o_ready  out  1  buffer can take a symbol this cycle.
- o_ak  out  WL  oversampled output sample, signed, registered.
- o_valid  out  1  o_ak updated this cycle (registered copy of i_enable).
- o_strobe  out  1  o_ak carries a symbol, i.e. the PHASE slot.
- o_underflow  out  1  one-cycle pulse: PHASE slot reached with empty buffer.

Behaviour:
- Reset values: slot counter = 0; buffer empty; last-symbol register = 0; o_ak = 0; o_valid, o_strobe, o_underflow = 0.
- o_ready = !full && !i_reset. It is combinational from the buffer flag and is 1 the first cycle after reset.
- Slot counter:
  - Width CL = max(1, clog2(N_OS)).
  - Increments only when i_enable=1 and wraps from N_OS-1 to 0.
  - Holds when i_enable=0.
  - The first enabled cycle after reset is slot 0.
- Buffer:
  - One entry plus a full flag.
  - Accept when i_valid && o_ready: load i_ak and set full.
  - Acceptance is independent of i_enable.
- Consume happens when i_enable=1 and counter==PHASE.
  - If full: next o_ak = buffer, last = buffer, o_strobe=1, and full clears.
  - If empty (underflow): next o_ak = 0, last = 0, o_strobe=1, o_underflow=1.
- Non-PHASE enabled slot: next o_ak = 0 (HOLD=0) or last (HOLD=1); o_strobe=0.
- No bypass: a symbol accepted in a consume cycle is not emitted in that cycle; it waits for the next PHASE slot. If the buffer is empty in that cycle, it underflows.
- Simultaneous accept and consume cannot occur while full, because o_ready=0. After consume clears full, o_ready rises the next cycle.
- Latency: output registers update on the clock edge of the enabled cycle, so o_ak/o_valid/o_strobe appear 1 clock after the enabled cycle.
- i_enable=0 cycles: o_valid=0, o_strobe=0, o_underflow=0; o_ak, counter and last hold.
- Throughput: at most one symbol per N_OS enabled cycles. A source holding i_valid=1 sees o_ready drop for N_OS-1 enabled cycles of each period (fewer if enable gaps occur).
- Arithmetic: none. Samples are passed verbatim; zero = all-zero WL bits.
- Reset mid-operation: asynchronously clears the buffer, counter and outputs; a pending symbol is discarded. After release, phase alignment restarts at slot 0.
- PHASE >= N_OS is illegal; flag with a simulation-time assertion.

Test Plan:
- Reset, then i_enable=1 continuously, i_valid=1 with i_ak sequence 1,-1,-2,0; N_OS=4, PHASE=0, HOLD=0 -> the first slot underflows (o_underflow pulse, o_ak=0). Afterwards o_ak = 1,0,0,0,-1,0,0,0,-2,0,0,0, and o_strobe is high every 4th o_valid.
- Same stimulus with PHASE=2, HOLD=1 -> each symbol appears at slots 2,3 of its period and at slots 0,1 of the next period. o_strobe is asserted only at slot 2.
- i_enable toggling 1,0,1,0,... with a symbol of 1 preloaded -> counter advances only on enabled cycles, and o_valid alternates. o_ak holds during gaps; the symbol is emitted once, 4 enabled cycles apart from the next.
- Source stalls (i_valid=0) for 2 baud periods -> o_underflow pulses exactly twice, o_ak=0 at those slots, and o_ready stays 1. Normal output resumes on the next symbol.
- Backpressure: hold i_valid=1 while the buffer is full -> o_ready=0 and i_ak changes are ignored. A transfer occurs only in cycles with o_ready=1, and no symbol is lost or duplicated (scoreboard compare).
- Assert i_reset mid-period with the buffer full -> o_ak=0 and o_ready=0 immediately (asynchronous). After release, o_ready=1, the counter restarts at 0, and the discarded symbol never appears.
